lsu_mem_port: RTL

- Memory-side counterpart of the main instruction decoder.
- Accepts one load/store request per instruction: size code, sign flag, address, store data.
- Runs a valid/ready transaction on the data-memory bus and returns the aligned, sign- or zero-extended load result or a store acknowledge.
- Sits between the execute stage and data memory; stalls the core while busy.

---
 rtl/lsu_mem_port_pkg.sv | 26 ++
 rtl/lsu_align.sv | 44 ++++
 rtl/lsu_mem_port.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/lsu_mem_port_pkg.sv
// rtl/lsu_mem_port_pkg.sv - LSU state encodings, access size codes and legality helper
package lsu_mem_port_pkg;

    localparam logic [1:0] LSU_IDLE = 2'd0;
    localparam logic [1:0] LSU_REQ  = 2'd1;
    localparam logic [1:0] LSU_WAIT = 2'd2;
    localparam logic [1:0] LSU_DONE = 2'd3;

    localparam logic [1:0] READ_BYTE = 2'b01;
    localparam logic [1:0] READ_HW   = 2'b10;
    localparam logic [1:0] READ_FW   = 2'b11;

    // Size 00 is reserved; halfwords need even and words 4-byte aligned addresses.
    function automatic logic access_ok(input logic [1:0] size, input logic [1:0] off);
        logic ok;
        ok = 1'b1;
        if (size == 2'b00)
            ok = 1'b0;
        else if (size == READ_HW && off[0])
            ok = 1'b0;
        else if (size == READ_FW && off != 2'b00)
            ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational store lane placement and load extraction/extension
module lsu_align
    import lsu_mem_port_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      size,
    input  logic [1:0]      off,
    input  logic            uns,
    input  logic [XLEN-1:0] wdata_in,
    input  logic [XLEN-1:0] rdata_in,
    output logic [3:0]      wmask,
    output logic [XLEN-1:0] wdata_out,
    output logic [XLEN-1:0] rdata_out
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted   = rdata_in >> {off, 3'b000};
        wmask     = 4'b0000;
        wdata_out = wdata_in;
        rdata_out = shifted;
        case (size)
            READ_BYTE: begin
                wmask     = 4'b0001 << off;
                wdata_out = {4{wdata_in[7:0]}};
                rdata_out = {{(XLEN-8){~uns & shifted[7]}}, shifted[7:0]};
            end
            READ_HW: begin
                wmask     = 4'b0011 << off;
                wdata_out = {2{wdata_in[15:0]}};
                rdata_out = {{(XLEN-16){~uns & shifted[15]}}, shifted[15:0]};
            end
            READ_FW: begin
                wmask = 4'b1111;
            end
            default: begin
                wmask = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - load/store unit bus port: request FSM, timeout and response
module lsu_mem_port
    import lsu_mem_port_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wr,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_wen,
    output logic [3:0]      mem_wmask,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_err,
    output logic            busy
);

    logic [1:0]      state;
    logic [1:0]      size_q;
    logic [1:0]      off_q;
    logic            wr_q;
    logic            uns_q;
    logic [7:0]      wait_cnt;

    logic [1:0]      al_size;
    logic [1:0]      al_off;
    logic [3:0]      al_wmask;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_rdata;

    // One aligner serves both directions: live request fields in IDLE, captured ones afterwards.
    assign al_size = (state == LSU_IDLE) ? req_size : size_q;
    assign al_off  = (state == LSU_IDLE) ? req_addr[1:0] : off_q;

    lsu_align #(.XLEN(XLEN)) u_align (
        .size      (al_size),
        .off       (al_off),
        .uns       (uns_q),
        .wdata_in  (req_wdata),
        .rdata_in  (mem_rdata),
        .wmask     (al_wmask),
        .wdata_out (al_wdata),
        .rdata_out (al_rdata)
    );

    assign req_ready = (state == LSU_IDLE);
    assign busy      = ~req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LSU_IDLE;
            size_q    <= 2'b00;
            off_q     <= 2'b00;
            wr_q      <= 1'b0;
            uns_q     <= 1'b0;
            wait_cnt  <= 8'd0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wmask <= 4'b0000;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            // Response outputs are a single-cycle pulse raised only on entry to DONE.
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            case (state)
                LSU_IDLE: begin
                    if (req_valid) begin
                        size_q <= req_size;
                        off_q  <= req_addr[1:0];
                        wr_q   <= req_wr;
                        uns_q  <= req_unsigned;
                        if (access_ok(req_size, req_addr[1:0])) begin
                            state     <= LSU_REQ;
                            mem_valid <= 1'b1;
                            mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
                            mem_wen   <= req_wr;
                            mem_wmask <= req_wr ? al_wmask : 4'b0000;
                            mem_wdata <= req_wr ? al_wdata : '0;
                        end else begin
                            state     <= LSU_DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                LSU_REQ: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        if (mem_rvalid) begin
                            state     <= LSU_DONE;
                            rsp_valid <= 1'b1;
                            rsp_data  <= wr_q ? '0 : al_rdata;
                        end else begin
                            state    <= LSU_WAIT;
                            wait_cnt <= 8'd0;
                        end
                    end
                end
                LSU_WAIT: begin
                    if (mem_rvalid) begin
                        state     <= LSU_DONE;
                        rsp_valid <= 1'b1;
                        rsp_data  <= wr_q ? '0 : al_rdata;
                    end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                        state     <= LSU_DONE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                LSU_DONE: begin
                    state <= LSU_IDLE;
                end
                default: begin
                    state <= LSU_IDLE;
                end
            endcase
        end
    end

endmodule
